// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared 640x480@60 raster timing constants for vga_sync and pixel_gen.
//   VGA_H_* / VGA_V_*  : visible area, porches and sync widths (pixels / lines)
//   VGA_H_TOTAL/V_TOTAL: derived line length and frame height
//   VGA_SYNC_ACTIVE    : level of hsync/vsync while the pulse is asserted
//   VGA_CLK_DIV        : system clocks per pixel
//   sync_level()       : maps "pulse asserted" to the physical pin level
// -----------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int VGA_H_DISPLAY = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;

    localparam int VGA_V_DISPLAY = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;

    localparam int VGA_H_TOTAL = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_V_TOTAL = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    localparam int VGA_CLK_DIV     = 4;
    localparam bit VGA_SYNC_ACTIVE = 1'b0;

    function automatic logic sync_level(input logic asserted, input logic active);
        return asserted ? active : ~active;
    endfunction

endpackage

// File: rtl/vga_sync_pixel_tick_gen.sv
// -----------------------------------------------------------------------------
// pixel_tick_gen
// Divides the system clock down to the pixel rate.
//   clk    : system clock
//   reset  : asynchronous, active-low
//   p_tick : one-clk pulse every CLK_DIV clocks (constant 1 when CLK_DIV==1)
// -----------------------------------------------------------------------------
module pixel_tick_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = VGA_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    // A one-bit counter is kept even for CLK_DIV==1: its wrap value is 0, so it
    // never leaves 0 and p_tick is 1 through and after reset.
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    if (CLK_DIV < 1) begin : g_clk_div_err
        $error("pixel_tick_gen: CLK_DIV must be at least 1");
    end

    logic [DW-1:0] div;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div <= '0;
        end else if (div == DIV_LAST) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    assign p_tick = (div == DIV_LAST);

endmodule

// File: rtl/vga_sync.sv
// -----------------------------------------------------------------------------
// vga_sync
// VGA raster timing generator: pixel enable, x/y counters, sync pulses and the
// active-video flag.
//   clk        : system clock
//   reset      : asynchronous, active-low
//   p_tick     : one-clk pulse per pixel period
//   x, y       : current horizontal / vertical count
//   video_on   : x < H_DISPLAY and y < V_DISPLAY
//   hsync      : horizontal sync, SYNC_ACTIVE while asserted
//   vsync      : vertical sync, SYNC_ACTIVE while asserted
//   frame_tick : one-clk pulse on the last pixel of a frame
// -----------------------------------------------------------------------------
module vga_sync
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY   = VGA_H_DISPLAY,
    parameter int H_FRONT     = VGA_H_FRONT,
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int H_BACK      = VGA_H_BACK,
    parameter int V_DISPLAY   = VGA_V_DISPLAY,
    parameter int V_FRONT     = VGA_V_FRONT,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int V_BACK      = VGA_V_BACK,
    parameter int CLK_DIV     = VGA_CLK_DIV,
    parameter bit SYNC_ACTIVE = VGA_SYNC_ACTIVE,
    parameter int X_BIT_WIDTH = 10,
    parameter int Y_BIT_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   p_tick,
    output logic [X_BIT_WIDTH-1:0] x,
    output logic [Y_BIT_WIDTH-1:0] y,
    output logic                   video_on,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   frame_tick
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    if (longint'(H_TOTAL - 1) >= (longint'(1) << X_BIT_WIDTH)) begin : g_x_width_err
        $error("vga_sync: H_TOTAL-1 does not fit in X_BIT_WIDTH");
    end
    if (longint'(V_TOTAL - 1) >= (longint'(1) << Y_BIT_WIDTH)) begin : g_y_width_err
        $error("vga_sync: V_TOTAL-1 does not fit in Y_BIT_WIDTH");
    end

    // All decode compares are done unsigned at counter width.
    localparam logic [X_BIT_WIDTH-1:0] X_LAST     = X_BIT_WIDTH'(H_TOTAL - 1);
    localparam logic [X_BIT_WIDTH-1:0] X_DISP     = X_BIT_WIDTH'(H_DISPLAY);
    localparam logic [X_BIT_WIDTH-1:0] HS_FIRST   = X_BIT_WIDTH'(H_DISPLAY + H_FRONT);
    localparam logic [X_BIT_WIDTH-1:0] HS_LAST    = X_BIT_WIDTH'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [Y_BIT_WIDTH-1:0] Y_LAST     = Y_BIT_WIDTH'(V_TOTAL - 1);
    localparam logic [Y_BIT_WIDTH-1:0] Y_DISP     = Y_BIT_WIDTH'(V_DISPLAY);
    localparam logic [Y_BIT_WIDTH-1:0] VS_FIRST   = Y_BIT_WIDTH'(V_DISPLAY + V_FRONT);
    localparam logic [Y_BIT_WIDTH-1:0] VS_LAST    = Y_BIT_WIDTH'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [X_BIT_WIDTH-1:0] x_next;
    logic [Y_BIT_WIDTH-1:0] y_next;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .p_tick (p_tick)
    );

    always_comb begin
        x_next = x;
        y_next = y;
        if (p_tick) begin
            if (x == X_LAST) begin
                x_next = '0;
                y_next = (y == Y_LAST) ? '0 : y + 1'b1;
            end else begin
                x_next = x + 1'b1;
            end
        end
    end

    // Flags are decoded from the next counts so they update on the same edge
    // as x/y and always describe the (x,y) currently on the outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x        <= '0;
            y        <= '0;
            video_on <= 1'b1;
            hsync    <= ~SYNC_ACTIVE;
            vsync    <= ~SYNC_ACTIVE;
        end else begin
            x        <= x_next;
            y        <= y_next;
            video_on <= (x_next < X_DISP) && (y_next < Y_DISP);
            hsync    <= sync_level((x_next >= HS_FIRST) && (x_next <= HS_LAST), SYNC_ACTIVE);
            vsync    <= sync_level((y_next >= VS_FIRST) && (y_next <= VS_LAST), SYNC_ACTIVE);
        end
    end

    assign frame_tick = p_tick && (x == X_LAST) && (y == Y_LAST);

endmodule

// File: tb/tb_vga_sync.sv
// -----------------------------------------------------------------------------
// tb_vga_sync
// Three instances: full 640x480 defaults (CLK_DIV=4), and a shrunken raster
// with CLK_DIV=1 / active-low sync and CLK_DIV=3 / active-high sync so that
// vertical wrap, vsync and frame_tick are reached quickly. Expected outputs are
// derived from the number of clock edges since reset release.
// -----------------------------------------------------------------------------
module tb_vga_sync;
    import vga_timing_pkg::*;

    // shrunken raster: 25 x 11
    localparam int SHD = 16, SHF = 2, SHS = 4, SHB = 3;
    localparam int SVD = 6,  SVF = 1, SVS = 2, SVB = 2;

    typedef struct packed {
        logic        p_tick;
        logic [15:0] x;
        logic [15:0] y;
        logic        video_on;
        logic        hsync;
        logic        vsync;
        logic        frame_tick;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   k;       // clock edges seen since reset release
    int   total = 0;
    int   bad   = 0;

    logic       d_p, d_v, d_h, d_vs, d_f;
    logic [9:0] d_x, d_y;
    logic       a_p, a_v, a_h, a_vs, a_f;
    logic [4:0] a_x;
    logic [3:0] a_y;
    logic       b_p, b_v, b_h, b_vs, b_f;
    logic [4:0] b_x;
    logic [3:0] b_y;

    always #5 clk = ~clk;

    vga_sync dut_def (
        .clk(clk), .reset(rst_n), .p_tick(d_p), .x(d_x), .y(d_y),
        .video_on(d_v), .hsync(d_h), .vsync(d_vs), .frame_tick(d_f)
    );

    vga_sync #(
        .H_DISPLAY(SHD), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_DISPLAY(SVD), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
        .CLK_DIV(1), .SYNC_ACTIVE(1'b0), .X_BIT_WIDTH(5), .Y_BIT_WIDTH(4)
    ) dut_a (
        .clk(clk), .reset(rst_n), .p_tick(a_p), .x(a_x), .y(a_y),
        .video_on(a_v), .hsync(a_h), .vsync(a_vs), .frame_tick(a_f)
    );

    vga_sync #(
        .H_DISPLAY(SHD), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_DISPLAY(SVD), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
        .CLK_DIV(3), .SYNC_ACTIVE(1'b1), .X_BIT_WIDTH(5), .Y_BIT_WIDTH(4)
    ) dut_b (
        .clk(clk), .reset(rst_n), .p_tick(b_p), .x(b_x), .y(b_y),
        .video_on(b_v), .hsync(b_h), .vsync(b_vs), .frame_tick(b_f)
    );

    // Raster position after k clocks: k/d pixels have elapsed, folded onto
    // the H_TOTAL x V_TOTAL grid.
    function automatic exp_t model(input int kk, input int hd, input int hf, input int hs,
                                   input int hb, input int vd, input int vf, input int vs,
                                   input int vb, input int d, input bit act);
        exp_t e;
        int ht, vt, n, xi, yi;
        ht = hd + hf + hs + hb;
        vt = vd + vf + vs + vb;
        n  = kk / d;
        xi = n % ht;
        yi = (n / ht) % vt;
        e.p_tick     = ((kk % d) == (d - 1));
        e.x          = 16'(xi);
        e.y          = 16'(yi);
        e.video_on   = (xi < hd) && (yi < vd);
        e.hsync      = (xi >= hd + hf && xi < hd + hf + hs) ? act : ~act;
        e.vsync      = (yi >= vd + vf && yi < vd + vf + vs) ? act : ~act;
        e.frame_tick = e.p_tick && (xi == ht - 1) && (yi == vt - 1);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s k=%0d observed=%0d expected=%0d", tag, k, obs, exp);
        end
    endtask

    task automatic check_one(input string nm, input exp_t e, input logic p,
                             input logic [15:0] xo, input logic [15:0] yo,
                             input logic v, input logic h, input logic vs, input logic f);
        chk({nm, ".p_tick"},     16'(p),  16'(e.p_tick));
        chk({nm, ".x"},          xo,      e.x);
        chk({nm, ".y"},          yo,      e.y);
        chk({nm, ".video_on"},   16'(v),  16'(e.video_on));
        chk({nm, ".hsync"},      16'(h),  16'(e.hsync));
        chk({nm, ".vsync"},      16'(vs), 16'(e.vsync));
        chk({nm, ".frame_tick"}, 16'(f),  16'(e.frame_tick));
    endtask

    task automatic check_all();
        check_one("def", model(k, VGA_H_DISPLAY, VGA_H_FRONT, VGA_H_SYNC, VGA_H_BACK,
                               VGA_V_DISPLAY, VGA_V_FRONT, VGA_V_SYNC, VGA_V_BACK, 4, 1'b0),
                  d_p, 16'(d_x), 16'(d_y), d_v, d_h, d_vs, d_f);
        check_one("a", model(k, SHD, SHF, SHS, SHB, SVD, SVF, SVS, SVB, 1, 1'b0),
                  a_p, 16'(a_x), 16'(a_y), a_v, a_h, a_vs, a_f);
        check_one("b", model(k, SHD, SHF, SHS, SHB, SVD, SVF, SVS, SVB, 3, 1'b1),
                  b_p, 16'(b_x), 16'(b_y), b_v, b_h, b_vs, b_f);
    endtask

    // Advance n clocks, checking every DUT at each falling edge.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (rst_n) k++;
            @(negedge clk);
            check_all();
        end
    endtask

    // Assert reset between edges and check outputs before any clock arrives.
    task automatic async_reset(input int hold);
        #2;
        rst_n = 1'b0;
        k     = 0;
        #1;
        check_all();
        run(hold);
    endtask

    task automatic release_reset();
        #2;
        rst_n = 1'b1;
        k     = 0;
    endtask

    initial begin
        k     = 0;
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check_all();
        run(3);

        // long first run: default instance crosses hsync (x=656..751) and wraps
        // a full 800-pixel line; small instances cover several full frames
        release_reset();
        run(3500);

        // random mid-frame resets and run lengths
        for (int seg = 0; seg < 8; seg++) begin
            async_reset($urandom_range(1, 5));
            release_reset();
            run($urandom_range(200, 2500));
        end

        // reset without any further clock activity check, then a short run
        async_reset(2);
        release_reset();
        run(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
